// File: rtl/text_pkg.sv
// text_pkg: shared constants and types for the text-mode pixel renderer.
package text_pkg;

    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;
    localparam int PAL_ENTRIES = 16;
    localparam int PAL_IW      = 4;

    // One character cell as stored in a 16-bit VRAM half-word.
    typedef struct packed {
        logic       invert;
        logic [6:0] code;
        logic [3:0] fg;
        logic [3:0] bg;
    } char_attr_t;

    // Native 4:4:4 pixel as handed on to the HDMI encoder.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/text_palette.sv
// text_palette: 16-entry colour register file. One write port, one registered
// read port. The read sees the value held before a same-edge write, and a
// blank request forces the read register to zero so it can feed the pins directly.
module text_palette
    import text_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [PAL_IW-1:0] widx,
    input  logic [3*CW-1:0]   wdata,
    input  logic [PAL_IW-1:0] ridx,
    input  logic              rblank,
    output logic [3*CW-1:0]   rdata
);

    logic [3*CW-1:0] mem [PAL_ENTRIES];

    // Palette storage: cleared on reset, written one entry per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Registered read, zeroed when the pixel is blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= rblank ? '0 : mem[ridx];
        end
    end

endmodule

// File: rtl/text_render_pipe.sv
// text_render_pipe: pipelined text-mode renderer. Scan position -> VRAM word
// -> font ROM row -> palette -> registered RGB, syncs delayed to match.
// Latency from inputs to outputs is VRAM_LAT + 2 cycles.
// Optional macro CURSOR_BLINK_EN adds a blinking block cursor.
// There is no valid/ready flow control: every stage advances on every pixel
// clock, and vde_in is carried alongside the data as its qualifier.
module text_render_pipe
    import text_pkg::*;
#(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int VRAM_AW  = 11,
    parameter int VRAM_LAT = 2,
    parameter int CW       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    input  logic               vde_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
`ifdef CURSOR_BLINK_EN
    input  logic [7:0]         cursor_col,
    input  logic [7:0]         cursor_row,
    input  logic               cursor_on,
`endif
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [31:0]        vram_rdata,
    output logic [10:0]        font_addr,
    input  logic [7:0]         font_data,
    input  logic               pal_we,
    input  logic [3:0]         pal_idx,
    input  logic [3*CW-1:0]    pal_wdata,
    output logic [CW-1:0]      red,
    output logic [CW-1:0]      green,
    output logic [CW-1:0]      blue,
    output logic               vde_out,
    output logic               hsync_out,
    output logic               vsync_out
);

    localparam int XS    = $clog2(GLYPH_W);
    localparam int YS    = $clog2(GLYPH_H);
    // One bit wider than the word address: bit 0 is the half-word select.
    localparam int IDX_W = VRAM_AW + 1;
    localparam logic [10:0] X_LIMIT = 11'(COLS * GLYPH_W);
    localparam logic [10:0] Y_LIMIT = 11'(ROWS * GLYPH_H);

    // Everything that must wait alongside the VRAM read.
    typedef struct packed {
        logic [XS-1:0] x;
        logic [YS-1:0] y;
        logic          h;
        logic          inb;
        logic          vde;
        logic          hs;
        logic          vs;
        logic          cur;
    } s0_t;

    // Everything that must wait alongside the font ROM read.
    typedef struct packed {
        logic          invert;
        logic [3:0]    fg;
        logic [3:0]    bg;
        logic [XS-1:0] x;
        logic          inb;
        logic          vde;
        logic          hs;
        logic          vs;
    } s1_t;

    logic [IDX_W-1:0] cell_idx;
    logic             cur_hit;
    s0_t              s0_now;
    s0_t              dl [VRAM_LAT];
    s0_t              s1_in;
    logic [15:0]      half;
    char_attr_t       attr;
    s1_t              s1_d;
    s1_t              s1_q;
    logic             pix;
    logic [3:0]       color_idx;
    logic             blank;
    logic [3*CW-1:0]  pal_rdata;

`ifdef CURSOR_BLINK_EN
    logic [5:0] frame_cnt;
    logic       vsync_d;

    // Frame counter advancing on each rising edge of vsync_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            vsync_d   <= 1'b0;
        end else begin
            vsync_d <= vsync_in;
            if (vsync_in && !vsync_d) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    assign cur_hit = cursor_on && frame_cnt[5] &&
                     ({1'b0, draw_x[9:XS]} == cursor_col) &&
                     ({4'b0, draw_y[9:YS]} == cursor_row);
`else
    assign cur_hit = 1'b0;
`endif

    // S0: cell index, VRAM word address and the side-band bits for the delay line.
    always_comb begin
        cell_idx   = IDX_W'(draw_y[9:YS]) * IDX_W'(COLS) + IDX_W'(draw_x[9:XS]);
        vram_addr  = cell_idx[IDX_W-1:1];
        s0_now     = '0;
        s0_now.x   = draw_x[XS-1:0];
        s0_now.y   = draw_y[YS-1:0];
        s0_now.h   = cell_idx[0];
        s0_now.inb = ({1'b0, draw_x} < X_LIMIT) && ({1'b0, draw_y} < Y_LIMIT);
        s0_now.vde = vde_in;
        s0_now.hs  = hsync_in;
        s0_now.vs  = vsync_in;
        s0_now.cur = cur_hit;
    end

    // S0 delay line, VRAM_LAT deep, so it lines up with vram_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < VRAM_LAT; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= s0_now;
            for (int i = 1; i < VRAM_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    assign s1_in = dl[VRAM_LAT-1];

    // S1: pick the half-word, request the glyph row, forward the attributes.
    always_comb begin
        half          = s1_in.h ? vram_rdata[31:16] : vram_rdata[15:0];
        attr          = char_attr_t'(half);
        font_addr     = {attr.code, s1_in.y};
        s1_d          = '0;
        s1_d.invert   = attr.invert ^ s1_in.cur;
        s1_d.fg       = attr.fg;
        s1_d.bg       = attr.bg;
        s1_d.x        = s1_in.x;
        s1_d.inb      = s1_in.inb;
        s1_d.vde      = s1_in.vde;
        s1_d.hs       = s1_in.hs;
        s1_d.vs       = s1_in.vs;
    end

    // S1 register, aligned with font_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // S2: glyph bit (MSB is the leftmost pixel), colour index and blanking.
    always_comb begin
        pix       = font_data[XS'(GLYPH_W - 1) - s1_q.x] ^ s1_q.invert;
        color_idx = pix ? s1_q.fg : s1_q.bg;
        blank     = !(s1_q.vde && s1_q.inb);
    end

    text_palette #(
        .CW (CW)
    ) u_palette (
        .clk    (clk),
        .reset  (reset),
        .we     (pal_we),
        .widx   (pal_idx),
        .wdata  (pal_wdata),
        .ridx   (color_idx),
        .rblank (blank),
        .rdata  (pal_rdata)
    );

    // S3: sync outputs registered in step with the palette read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            vde_out   <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            vde_out   <= s1_q.vde;
            hsync_out <= s1_q.hs;
            vsync_out <= s1_q.vs;
        end
    end

    assign {red, green, blue} = pal_rdata;

endmodule

// File: tb/tb_text_render_pipe.sv
// tb_text_render_pipe: randomized and directed stimulus for text_render_pipe,
// with a cell-level reference model, VRAM/font ROM models and an expected queue.
module tb_text_render_pipe;
    import text_pkg::*;

    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int VRAM_AW  = 11;
    localparam int VRAM_LAT = 2;
    localparam int CW       = 4;
    localparam int L        = VRAM_LAT + 2;

    logic               clk       = 1'b0;
    logic               reset     = 1'b1;
    logic [9:0]         draw_x    = '0;
    logic [9:0]         draw_y    = '0;
    logic               vde_in    = 1'b0;
    logic               hsync_in  = 1'b0;
    logic               vsync_in  = 1'b0;
    logic [VRAM_AW-1:0] vram_addr;
    logic [31:0]        vram_rdata;
    logic [10:0]        font_addr;
    logic [7:0]         font_data;
    logic               pal_we    = 1'b0;
    logic [3:0]         pal_idx   = '0;
    logic [3*CW-1:0]    pal_wdata = '0;
    logic [CW-1:0]      red;
    logic [CW-1:0]      green;
    logic [CW-1:0]      blue;
    logic               vde_out;
    logic               hsync_out;
    logic               vsync_out;
`ifdef CURSOR_BLINK_EN
    logic [7:0]         cursor_col = '0;
    logic [7:0]         cursor_row = '0;
    logic               cursor_on  = 1'b0;
`endif

    text_render_pipe #(
        .COLS (COLS), .ROWS (ROWS), .VRAM_AW (VRAM_AW), .VRAM_LAT (VRAM_LAT), .CW (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .vde_in     (vde_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
`ifdef CURSOR_BLINK_EN
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .cursor_on  (cursor_on),
`endif
        .vram_addr  (vram_addr),
        .vram_rdata (vram_rdata),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .pal_we     (pal_we),
        .pal_idx    (pal_idx),
        .pal_wdata  (pal_wdata),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .vde_out    (vde_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory models ----------------
    logic [31:0] vram_mem [1 << VRAM_AW];
    logic [31:0] rd_pipe  [VRAM_LAT];
    logic [7:0]  font_q;

    function automatic logic [7:0] font_rom(input logic [10:0] a);
        logic [15:0] h;
        h = {5'b0, a} * 16'd40503;
        return h[15:8] ^ a[7:0];
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= vram_mem[vram_addr];
        for (int i = 1; i < VRAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign vram_rdata = rd_pipe[VRAM_LAT-1];

    always @(posedge clk) font_q <= font_rom(font_addr);
    assign font_data = font_q;

    // ---------------- reference model ----------------
    // Record layout: {vde, hsync, vsync, out_of_bounds, colour_index}
    logic [7:0]  exp_q [$];
    logic [11:0] pal_m  [16];
    logic [11:0] pal_d1 [16];
    rgb_t        obs_rgb;
    logic        obs_vde;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [7:0] model_pix(input int x, input int y,
                                             input logic vde, input logic hs, input logic vs);
        int          idx;
        logic [31:0] word;
        logic [15:0] hw;
        logic [7:0]  glyph;
        logic        oob;
        logic        p;
        logic [3:0]  ci;
        oob   = (x >= COLS * 8) || (y >= ROWS * 16);
        idx   = (y / 16) * COLS + x / 8;
        word  = vram_mem[(idx / 2) % (1 << VRAM_AW)];
        hw    = (idx % 2 == 1) ? word[31:16] : word[15:0];
        glyph = font_rom({hw[14:8], 4'(y % 16)});
        p     = glyph[7 - (x % 8)] ^ hw[15];
        ci    = p ? hw[7:4] : hw[3:0];
        if (oob) ci = 4'h0;
        return {vde, hs, vs, oob, ci};
    endfunction

    function automatic logic [VRAM_AW-1:0] model_addr(input int x, input int y);
        return VRAM_AW'((((y / 16) * COLS + x / 8) / 2) % (1 << VRAM_AW));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One pixel clock: check this cycle's outputs, then drive the next inputs.
    task automatic step(input logic rst, input logic [9:0] x, input logic [9:0] y,
                        input logic vde, input logic hs, input logic vs,
                        input logic we, input logic [3:0] widx, input logic [11:0] wdata);
        logic [7:0]  rec;
        logic [11:0] want_rgb;
        @(posedge clk);
        #1;
        rec      = exp_q.pop_front();
        want_rgb = (rec[7] && !rec[4]) ? pal_d1[rec[3:0]] : 12'h000;
        obs_rgb  = {red, green, blue};
        obs_vde  = vde_out;
        chk("rgb",       32'(obs_rgb),   32'(want_rgb));
        chk("vde_out",   32'(vde_out),   32'(rec[7]));
        chk("hsync_out", 32'(hsync_out), 32'(rec[6]));
        chk("vsync_out", 32'(vsync_out), 32'(rec[5]));
        pal_d1 = pal_m;
        reset     = rst;
        draw_x    = x;
        draw_y    = y;
        vde_in    = vde;
        hsync_in  = hs;
        vsync_in  = vs;
        pal_we    = we;
        pal_idx   = widx;
        pal_wdata = wdata;
        if (rst) begin
            exp_q.delete();
            repeat (L) exp_q.push_back(8'h00);
            for (int i = 0; i < 16; i++) pal_m[i] = '0;
        end else begin
            exp_q.push_back(model_pix(int'(x), int'(y), vde, hs, vs));
            if (we) pal_m[widx] = wdata;
        end
        #1;
        chk("vram_addr", 32'(vram_addr), 32'(model_addr(int'(x), int'(y))));
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic vde);
        step(1'b0, x, y, vde, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);
    endtask

    task automatic idle();
        step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);
    endtask

    task automatic pal_write(input logic [3:0] widx, input logic [11:0] wdata);
        step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, widx, wdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < (1 << VRAM_AW); i++) vram_mem[i] = $urandom;
        vram_mem[0] = 32'hC112_4112;                 // cell 0: 'A' fg1 bg2, cell 1: same inverted
        vram_mem[1] = {16'($urandom), 16'h0011};     // cell 2: fg = bg = 1
        for (int i = 0; i < 16; i++) begin
            pal_m[i]  = '0;
            pal_d1[i] = '0;
        end
        repeat (3) @(posedge clk);
        repeat (L) exp_q.push_back(8'h00);

        // Reset state.
        step(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);
        step(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);

        // vde at (0,0), palette all zero: vde_out rises exactly L cycles later.
        pixel(10'd0, 10'd0, 1'b1);
        idle();
        idle();
        idle();
        chk("vde_lat_early", 32'(obs_vde), 32'd0);
        idle();
        chk("vde_lat_exact", 32'(obs_vde), 32'd1);
        chk("rgb_pal_zero",  32'(obs_rgb), 32'h000);

        // Palette 1 = red, 2 = blue; scan row 5 across cells 0 (plain) and 1 (inverted).
        pal_write(4'd1, 12'hF00);
        pal_write(4'd2, 12'h00F);
        for (int x = 0; x < 16; x++) pixel(10'(x), 10'd5, 1'b1);
        repeat (L) idle();

        // Out of bounds: still addressed, never coloured.
        pixel(10'd645, 10'd200, 1'b1);
        chk("oob_addr", 32'(vram_addr), 32'd520);
        repeat (L) idle();
        chk("oob_rgb", 32'(obs_rgb), 32'h000);

        // Palette write in the same cycle S2 reads the entry: old value first.
        pixel(10'd16, 10'd0, 1'b1);
        pixel(10'd17, 10'd0, 1'b1);
        idle();
        pal_write(4'd1, 12'h0F0);
        idle();
        chk("rbw_old", 32'(obs_rgb), 32'hF00);
        idle();
        chk("rbw_new", 32'(obs_rgb), 32'h0F0);

        // Randomized traffic with occasional palette writes and mid-frame resets.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 149) == 0,
                 10'($urandom_range(0, 703)), 10'($urandom_range(0, 524)),
                 $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 5) == 0, 4'($urandom), 12'($urandom));
        end
        repeat (L) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
